pim_result_reader: RTL and testbench
====================================

Name: pim_result_reader

Overview:
- Readout sequencer directly downstream of the PIM result buffer (256 x 32-bit words captured from the 8192-bit PIM output).
- On a start command it drives the buffer's word index and read-enable.
- It registers each returned word and streams the words to the bus-side consumer over a valid/ready interface, at up to one word per cycle, with completion status.

Parameters:
- NUM_WORDS, 256, result buffer depth in 32-bit words.
- IDX_W, 8, word index width (log2 NUM_WORDS).
- LEN_W, 9, length/count width (IDX_W+1).

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  start readout; sampled only in IDLE.
- i_abort  input  1  cancel readout in progress.
- i_num_words  input  LEN_W  words to read, starting at index 0; 0 encodes NUM_WORDS; values above NUM_WORDS are clamped to NUM_WORDS.
- o_result_out_en  output  1  read enable to the result buffer (combinational).
- o_counter  output  IDX_W  word index to the result buffer (registered read pointer).
- i_buf_data  input  32  word returned combinationally by the result buffer for o_counter.
- o_valid  output  1  stream data valid.
- o_data  output  32  stream data.
- i_ready  input  1  consumer ready.
- o_busy  output  1  readout in progress.
- o_done  output  1  one-cycle completion pulse.
- o_words_sent  output  LEN_W  accepted transfers in the current or last readout.

Behaviour:
- Reset: state=IDLE; rd_idx=0, len=0; o_valid, o_data, o_busy, o_done, o_words_sent all 0; o_result_out_en=0, o_counter=0. Reset has priority over everything, including mid-readout.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - o_result_out_en=0.
  - i_start=1 and i_abort=0: latch len (after 0/clamp encoding), clear rd_idx and o_words_sent, go to RUN.
  - i_start together with i_abort: start is ignored.
- RUN:
  - o_busy=1.
  - load = (rd_idx < len) && (!o_valid || i_ready).
  - o_result_out_en = load; o_counter = rd_idx[IDX_W-1:0].
  - On load: o_data <= i_buf_data, o_valid <= 1, rd_idx++.
  - Handshake without load (o_valid && i_ready && !load): o_valid <= 0.
  - Each handshake increments o_words_sent.
  - The handshake that makes o_words_sent == len moves the FSM to DONE.
- DONE: o_done=1 and o_busy=0 for exactly one cycle, then IDLE. o_words_sent and o_counter hold until the next start.
- Stream rules:
  - Once o_valid=1, o_data is stable until a handshake.
  - o_valid never drops without a handshake, except on abort or reset.
  - Sustained i_ready=1 yields one word per cycle, with no bubbles.
- Latency: start sampled at edge 0; RUN from cycle 1, with o_result_out_en=1 and o_counter=0; o_valid=1 with word 0 from cycle 2.
- Backpressure: i_ready=0 with o_valid=1 gives load=0. rd_idx, o_counter and o_data freeze and o_result_out_en=0.
- Wrap: rd_idx is LEN_W wide and reaches len (max 256) without aliasing. o_counter shows rd_idx[7:0], but o_result_out_en is 0 whenever rd_idx == len.
- Abort:
  - i_abort in RUN: next edge gives IDLE and o_valid=0; no o_done pulse; o_words_sent keeps the handshakes completed so far.
  - A handshake in the abort cycle is still counted.
  - i_abort in IDLE or DONE has no effect.
- i_start while in RUN or DONE is ignored; no queuing.
- Single word (i_num_words=1): out_en for one cycle, one transfer, done pulse.

Test Plan:
- Buffer loaded with buffer[k]=0xA5000000+k; i_num_words=0; i_ready held 1 -> 256 transfers with data 0xA5000000..0xA50000FF in consecutive cycles; first o_valid 2 cycles after start; o_done one cycle after the last handshake; o_words_sent=256.
- i_num_words=4; i_ready toggles 1,0,0,1,1,0,1 -> words 0..3 delivered in order, o_data stable while stalled, o_counter frozen while stalled, exactly 4 handshakes, one o_done.
- i_num_words=300 -> clamped to 256; o_result_out_en never asserted with rd_idx=256.
- i_num_words=8, i_abort after 3 handshakes -> o_valid=0 next cycle, no o_done, o_busy=0, o_words_sent=3; a subsequent start with i_num_words=2 returns words 0,1.
- i_start pulsed during RUN, and i_start together with i_abort in IDLE -> both ignored (no restart, state stays IDLE).
- i_rst asserted mid-readout with o_valid=1 -> next cycle all outputs 0 and state IDLE.

Source files
------------

// File: rtl/pim_result_reader.sv
// Readout sequencer for the PIM result buffer: walks word indices 0..len-1 and
// streams the returned words over a valid/ready interface with completion status.
module pim_result_reader #(
  parameter int unsigned NUM_WORDS = 256,
  parameter int unsigned IDX_W     = 8,
  parameter int unsigned LEN_W     = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [LEN_W-1:0] i_num_words,
  output logic             o_result_out_en,
  output logic [IDX_W-1:0] o_counter,
  input  logic [31:0]      i_buf_data,
  output logic             o_valid,
  output logic [31:0]      o_data,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN_W-1:0] o_words_sent
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rd_idx_q, rd_idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] sent_q, sent_d;
  logic             valid_q, valid_d;
  logic [31:0]      data_q, data_d;
  logic             load, hs;
  logic [LEN_W-1:0] num_enc;

  // Zero means a full buffer; oversized requests are clamped to the buffer depth.
  always_comb begin
    num_enc = i_num_words;
    if (i_num_words == '0 || i_num_words > LEN_W'(NUM_WORDS)) begin
      num_enc = LEN_W'(NUM_WORDS);
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    len_d    = len_q;
    sent_d   = sent_q;
    valid_d  = valid_q;
    data_d   = data_q;
    load     = 1'b0;
    hs       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start && !i_abort) begin
          len_d    = num_enc;
          rd_idx_d = '0;
          sent_d   = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        // The output register refills whenever it is empty or being drained.
        load = (rd_idx_q < len_q) && (!valid_q || i_ready);
        hs   = valid_q && i_ready;
        if (load) begin
          data_d   = i_buf_data;
          valid_d  = 1'b1;
          rd_idx_d = rd_idx_q + LEN_W'(1);
        end else if (hs) begin
          valid_d = 1'b0;
        end
        if (hs) begin
          sent_d = sent_q + LEN_W'(1);
        end
        if (i_abort) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (hs && (sent_q + LEN_W'(1)) == len_q) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      rd_idx_q <= '0;
      len_q    <= '0;
      sent_q   <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
      len_q    <= len_d;
      sent_q   <= sent_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign o_result_out_en = load;
  assign o_counter       = rd_idx_q[IDX_W-1:0];
  assign o_valid         = valid_q;
  assign o_data          = data_q;
  assign o_busy          = (state_q == StRun);
  assign o_done          = (state_q == StDone);
  assign o_words_sent    = sent_q;

endmodule

// File: tb/tb_pim_result_reader.sv
// Scoreboard bench for pim_result_reader: expected words are queued at start,
// a negedge monitor pops and compares on every handshake.
module tb_pim_result_reader;
  localparam int NW = 256;
  localparam int IW = 8;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          rst, start, abort, ready;
  logic [LW-1:0] num;
  logic          out_en, valid, busy, done;
  logic [IW-1:0] counter;
  logic [31:0]   buf_data, data;
  logic [LW-1:0] words_sent;
  logic [31:0]   mem [NW];

  assign buf_data = mem[counter];
  always #5 clk = ~clk;

  pim_result_reader #(.NUM_WORDS(NW), .IDX_W(IW), .LEN_W(LW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_num_words(num),
    .o_result_out_en(out_en), .o_counter(counter), .i_buf_data(buf_data),
    .o_valid(valid), .o_data(data), .i_ready(ready), .o_busy(busy), .o_done(done),
    .o_words_sent(words_sent)
  );

  int          n_cmp = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  int          hs_cnt = 0, oe_cnt = 0, done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops, read-address model, stall stability.
  initial begin
    logic        pv, pr, pab, prst;
    logic [31:0] pd;
    logic [IW-1:0] pc;
    pv = 0; pr = 0; pab = 0; prst = 1; pd = 0; pc = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (valid && ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_word: got 0x%0h expected no transfer", data);
          end else begin
            check("stream_data", data, exp_q.pop_front());
          end
          hs_cnt++;
        end
        if (out_en) begin
          check("rd_addr", 32'(counter), 32'(oe_cnt % NW));
          check("oe_while_busy", 32'(busy), 1);
          oe_cnt++;
        end
        if (pv && !pr && !pab && !prst) begin
          check("stall_valid", 32'(valid), 1);
          check("stall_data", data, pd);
          check("stall_counter", 32'(counter), 32'(pc));
        end
        if (done) done_cnt++;
      end
      pv = valid; pr = ready; pab = abort; prst = rst; pd = data; pc = counter;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input bit pat);
    for (int k = 0; k < NW; k++) mem[k] = pat ? 32'hA500_0000 + 32'(k) : $urandom;
  endtask

  function automatic int eff_len(input int n);
    return (n == 0 || n > NW) ? NW : n;
  endfunction

  task automatic do_start(input int n);
    for (int k = 0; k < eff_len(n); k++) exp_q.push_back(mem[k]);
    hs_cnt = 0; oe_cnt = 0; done_cnt = 0;
    start = 1'b1;
    num   = LW'(n);
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready held high, 1: random ready, 2: fixed toggle pattern
  task automatic run(input int mode, input int n_exp, input bit lat);
    bit pat [7];
    bit seen;
    int c;
    pat = '{1, 0, 0, 1, 1, 0, 1};
    seen = 0;
    for (c = 1; c <= 4000; c++) begin
      case (mode)
        0: ready = 1'b1;
        1: ready = ($urandom_range(0, 9) < 7);
        default: ready = (c >= 2 && c - 2 < 7) ? pat[c-2] : 1'b1;
      endcase
      if (mode == 2) begin
        start = (c == 3);
        num   = 9'd5;
      end
      @(negedge clk);
      if (lat && c == 1) begin
        check("lat_busy", 32'(busy), 1);
        check("lat_out_en", 32'(out_en), 1);
        check("lat_counter", 32'(counter), 0);
        check("lat_valid_c1", 32'(valid), 0);
      end
      if (lat && c == 2) check("lat_valid_c2", 32'(valid), 1);
      if (done) begin
        seen = 1;
        break;
      end
      tick();
    end
    start = 1'b0;
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: got no o_done expected o_done within 4000 cycles");
    end
    if (mode == 0) check("done_cycle", 32'(c), 32'(n_exp + 2));
    check("done_words_sent", 32'(words_sent), 32'(n_exp));
    check("done_busy", 32'(busy), 0);
    check("oe_count", 32'(oe_cnt), 32'(n_exp));
    check("hs_count", 32'(hs_cnt), 32'(n_exp));
    check("queue_drained", 32'(exp_q.size()), 0);
    tick();
    check("done_one_cycle", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_words_hold", 32'(words_sent), 32'(n_exp));
    check("done_count", 32'(done_cnt), 1);
  endtask

  initial begin
    int n;
    rst = 1; start = 0; abort = 0; ready = 0; num = '0;
    fill(1);
    repeat (3) tick();
    check("rst_valid", 32'(valid), 0);
    check("rst_data", data, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_words", 32'(words_sent), 0);
    check("rst_out_en", 32'(out_en), 0);
    check("rst_counter", 32'(counter), 0);
    rst = 0;
    tick();

    // Full buffer, no backpressure
    do_start(0);
    run(0, 256, 1);

    // Short readout with stalls; start pulse mid-run must be ignored
    fill(0);
    do_start(4);
    run(2, 4, 0);

    // Oversized request is clamped
    do_start(300);
    run(1, 256, 0);

    // Abort after three handshakes with the consumer stalled
    do_start(8);
    ready = 1;
    for (int i = 0; i < 100 && hs_cnt < 3; i++) tick();
    abort = 1; ready = 0;
    tick();
    abort = 0;
    check("abort_valid", 32'(valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_words", 32'(words_sent), 3);
    exp_q.delete();
    tick();
    check("abort_no_done", 32'(done_cnt), 0);
    do_start(2);
    run(0, 2, 0);

    // Abort with a handshake in the same cycle: that transfer still counts
    do_start(20);
    ready = 1;
    for (int i = 0; i < 100 && hs_cnt < 5; i++) tick();
    abort = 1;
    tick();
    abort = 0;
    check("abort_hs_words", 32'(words_sent), 32'(hs_cnt));
    check("abort_hs_valid", 32'(valid), 0);
    exp_q.delete();
    tick();

    // Start together with abort in idle is ignored
    start = 1; abort = 1; num = 9'd3;
    tick();
    start = 0; abort = 0;
    check("sa_busy", 32'(busy), 0);
    check("sa_out_en", 32'(out_en), 0);
    tick();
    check("sa_busy2", 32'(busy), 0);
    check("sa_valid", 32'(valid), 0);

    // Randomized readouts
    for (int i = 0; i < 6; i++) begin
      fill(0);
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      do_start(n);
      run(1, eff_len(n), 0);
    end

    // Reset in the middle of a stalled readout
    do_start(16);
    ready = 0;
    for (int i = 0; i < 10 && !valid; i++) tick();
    tick();
    rst = 1;
    tick();
    check("mrst_valid", 32'(valid), 0);
    check("mrst_data", data, 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_done", 32'(done), 0);
    check("mrst_words", 32'(words_sent), 0);
    check("mrst_out_en", 32'(out_en), 0);
    check("mrst_counter", 32'(counter), 0);
    rst = 0;
    exp_q.delete();
    tick();
    check("mrst_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
